axi_rd_arbiter: RTL and testbench

Shares the single 64-bit AXI4 memory master port between the instruction fetch unit (IFU) and the load/store unit (LSU). The read channels AR/R are arbitrated round-robin, and one burst is granted at a time. The write channels AW/W/B are owned by the LSU. LSU reads are held off while an LSU write is outstanding. The block sits between the IFU/LSU AXI masters and the memory/crossbar port.

---
 rtl/axi_rd_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 master port between the IFU and the LSU.
// Reads are arbitrated round-robin, one burst per grant. The LSU owns the
// write channels. LSU reads wait while one of its writes is still outstanding.
module axi_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    // IFU read address / read data
    input  logic              IFU_AXI_ARVALID,
    output logic              IFU_AXI_ARREADY,
    input  logic [ID_W-1:0]   IFU_AXI_ARID,
    input  logic [ADDR_W-1:0] IFU_AXI_ARADDR,
    input  logic [7:0]        IFU_AXI_ARLEN,
    input  logic [2:0]        IFU_AXI_ARSIZE,
    input  logic [1:0]        IFU_AXI_ARBURST,
    input  logic              IFU_AXI_ARLOCK,
    input  logic [3:0]        IFU_AXI_ARCACHE,
    input  logic [2:0]        IFU_AXI_ARPROT,
    input  logic [3:0]        IFU_AXI_ARQOS,
    input  logic [3:0]        IFU_AXI_ARREGION,
    output logic              IFU_AXI_RVALID,
    input  logic              IFU_AXI_RREADY,
    output logic [ID_W-1:0]   IFU_AXI_RID,
    output logic [DATA_W-1:0] IFU_AXI_RDATA,
    output logic [1:0]        IFU_AXI_RRESP,
    output logic              IFU_AXI_RLAST,
    // IFU write channels (never granted)
    input  logic              IFU_AXI_AWVALID,
    output logic              IFU_AXI_AWREADY,
    input  logic [ID_W-1:0]   IFU_AXI_AWID,
    input  logic [ADDR_W-1:0] IFU_AXI_AWADDR,
    input  logic [7:0]        IFU_AXI_AWLEN,
    input  logic [2:0]        IFU_AXI_AWSIZE,
    input  logic [1:0]        IFU_AXI_AWBURST,
    input  logic              IFU_AXI_AWLOCK,
    input  logic [3:0]        IFU_AXI_AWCACHE,
    input  logic [2:0]        IFU_AXI_AWPROT,
    input  logic [3:0]        IFU_AXI_AWQOS,
    input  logic [3:0]        IFU_AXI_AWREGION,
    input  logic              IFU_AXI_WVALID,
    output logic              IFU_AXI_WREADY,
    input  logic [DATA_W-1:0] IFU_AXI_WDATA,
    input  logic [DATA_W/8-1:0] IFU_AXI_WSTRB,
    input  logic              IFU_AXI_WLAST,
    output logic              IFU_AXI_BVALID,
    input  logic              IFU_AXI_BREADY,
    output logic [ID_W-1:0]   IFU_AXI_BID,
    output logic [1:0]        IFU_AXI_BRESP,
    // LSU read address / read data
    input  logic              LSU_AXI_ARVALID,
    output logic              LSU_AXI_ARREADY,
    input  logic [ID_W-1:0]   LSU_AXI_ARID,
    input  logic [ADDR_W-1:0] LSU_AXI_ARADDR,
    input  logic [7:0]        LSU_AXI_ARLEN,
    input  logic [2:0]        LSU_AXI_ARSIZE,
    input  logic [1:0]        LSU_AXI_ARBURST,
    input  logic              LSU_AXI_ARLOCK,
    input  logic [3:0]        LSU_AXI_ARCACHE,
    input  logic [2:0]        LSU_AXI_ARPROT,
    input  logic [3:0]        LSU_AXI_ARQOS,
    input  logic [3:0]        LSU_AXI_ARREGION,
    output logic              LSU_AXI_RVALID,
    input  logic              LSU_AXI_RREADY,
    output logic [ID_W-1:0]   LSU_AXI_RID,
    output logic [DATA_W-1:0] LSU_AXI_RDATA,
    output logic [1:0]        LSU_AXI_RRESP,
    output logic              LSU_AXI_RLAST,
    // LSU write channels
    input  logic              LSU_AXI_AWVALID,
    output logic              LSU_AXI_AWREADY,
    input  logic [ID_W-1:0]   LSU_AXI_AWID,
    input  logic [ADDR_W-1:0] LSU_AXI_AWADDR,
    input  logic [7:0]        LSU_AXI_AWLEN,
    input  logic [2:0]        LSU_AXI_AWSIZE,
    input  logic [1:0]        LSU_AXI_AWBURST,
    input  logic              LSU_AXI_AWLOCK,
    input  logic [3:0]        LSU_AXI_AWCACHE,
    input  logic [2:0]        LSU_AXI_AWPROT,
    input  logic [3:0]        LSU_AXI_AWQOS,
    input  logic [3:0]        LSU_AXI_AWREGION,
    input  logic              LSU_AXI_WVALID,
    output logic              LSU_AXI_WREADY,
    input  logic [DATA_W-1:0] LSU_AXI_WDATA,
    input  logic [DATA_W/8-1:0] LSU_AXI_WSTRB,
    input  logic              LSU_AXI_WLAST,
    output logic              LSU_AXI_BVALID,
    input  logic              LSU_AXI_BREADY,
    output logic [ID_W-1:0]   LSU_AXI_BID,
    output logic [1:0]        LSU_AXI_BRESP,
    // Shared master port
    output logic              AXI_ARVALID,
    input  logic              AXI_ARREADY,
    output logic [ID_W-1:0]   AXI_ARID,
    output logic [ADDR_W-1:0] AXI_ARADDR,
    output logic [7:0]        AXI_ARLEN,
    output logic [2:0]        AXI_ARSIZE,
    output logic [1:0]        AXI_ARBURST,
    output logic              AXI_ARLOCK,
    output logic [3:0]        AXI_ARCACHE,
    output logic [2:0]        AXI_ARPROT,
    output logic [3:0]        AXI_ARQOS,
    output logic [3:0]        AXI_ARREGION,
    input  logic              AXI_RVALID,
    output logic              AXI_RREADY,
    input  logic [ID_W-1:0]   AXI_RID,
    input  logic [DATA_W-1:0] AXI_RDATA,
    input  logic [1:0]        AXI_RRESP,
    input  logic              AXI_RLAST,
    output logic              AXI_AWVALID,
    input  logic              AXI_AWREADY,
    output logic [ID_W-1:0]   AXI_AWID,
    output logic [ADDR_W-1:0] AXI_AWADDR,
    output logic [7:0]        AXI_AWLEN,
    output logic [2:0]        AXI_AWSIZE,
    output logic [1:0]        AXI_AWBURST,
    output logic              AXI_AWLOCK,
    output logic [3:0]        AXI_AWCACHE,
    output logic [2:0]        AXI_AWPROT,
    output logic [3:0]        AXI_AWQOS,
    output logic [3:0]        AXI_AWREGION,
    output logic              AXI_WVALID,
    input  logic              AXI_WREADY,
    output logic [DATA_W-1:0] AXI_WDATA,
    output logic [DATA_W/8-1:0] AXI_WSTRB,
    output logic              AXI_WLAST,
    input  logic              AXI_BVALID,
    output logic              AXI_BREADY,
    input  logic [ID_W-1:0]   AXI_BID,
    input  logic [1:0]        AXI_BRESP
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_IFU  = 2'd1;
    localparam logic [1:0] R_LSU  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       ar_done_q, ar_done_d;
    logic       last_lsu_q, last_lsu_d;
    logic       wr_pend_q, wr_pend_d;
    logic       gnt_ifu, gnt_lsu;
    logic       unused_ifu_wr;

    // Grants are masked by reset so every handshake output is quiet while rst=1
    assign gnt_ifu = (state_q == R_IFU) && !rst;
    assign gnt_lsu = (state_q == R_LSU) && !rst;

    // The IFU write side sinks everything and never answers
    assign IFU_AXI_AWREADY = 1'b0;
    assign IFU_AXI_WREADY  = 1'b0;
    assign IFU_AXI_BVALID  = 1'b0;
    assign IFU_AXI_BID     = '0;
    assign IFU_AXI_BRESP   = '0;
    assign unused_ifu_wr = ^{IFU_AXI_AWVALID, IFU_AXI_AWID, IFU_AXI_AWADDR, IFU_AXI_AWLEN,
                             IFU_AXI_AWSIZE, IFU_AXI_AWBURST, IFU_AXI_AWLOCK, IFU_AXI_AWCACHE,
                             IFU_AXI_AWPROT, IFU_AXI_AWQOS, IFU_AXI_AWREGION, IFU_AXI_WVALID,
                             IFU_AXI_WDATA, IFU_AXI_WSTRB, IFU_AXI_WLAST, IFU_AXI_BREADY};

    // LSU write channels pass straight through to the shared port
    assign AXI_AWVALID     = LSU_AXI_AWVALID && !rst;
    assign LSU_AXI_AWREADY = AXI_AWREADY && !rst;
    assign AXI_AWID        = LSU_AXI_AWID;
    assign AXI_AWADDR      = LSU_AXI_AWADDR;
    assign AXI_AWLEN       = LSU_AXI_AWLEN;
    assign AXI_AWSIZE      = LSU_AXI_AWSIZE;
    assign AXI_AWBURST     = LSU_AXI_AWBURST;
    assign AXI_AWLOCK      = LSU_AXI_AWLOCK;
    assign AXI_AWCACHE     = LSU_AXI_AWCACHE;
    assign AXI_AWPROT      = LSU_AXI_AWPROT;
    assign AXI_AWQOS       = LSU_AXI_AWQOS;
    assign AXI_AWREGION    = LSU_AXI_AWREGION;
    assign AXI_WVALID      = LSU_AXI_WVALID && !rst;
    assign LSU_AXI_WREADY  = AXI_WREADY && !rst;
    assign AXI_WDATA       = LSU_AXI_WDATA;
    assign AXI_WSTRB       = LSU_AXI_WSTRB;
    assign AXI_WLAST       = LSU_AXI_WLAST;
    assign LSU_AXI_BVALID  = AXI_BVALID && !rst;
    assign AXI_BREADY      = LSU_AXI_BREADY && !rst;
    assign LSU_AXI_BID     = AXI_BID;
    assign LSU_AXI_BRESP   = AXI_BRESP;

    // Read-channel mux: the granted master is wired to AR/R, everyone else sees zeros
    always_comb begin
        AXI_ARVALID = 1'b0;   AXI_ARID = '0;     AXI_ARADDR = '0;   AXI_ARLEN = '0;
        AXI_ARSIZE = '0;      AXI_ARBURST = '0;  AXI_ARLOCK = 1'b0; AXI_ARCACHE = '0;
        AXI_ARPROT = '0;      AXI_ARQOS = '0;    AXI_ARREGION = '0; AXI_RREADY = 1'b0;
        IFU_AXI_ARREADY = 1'b0; IFU_AXI_RVALID = 1'b0; IFU_AXI_RID = '0;
        IFU_AXI_RDATA = '0;   IFU_AXI_RRESP = '0; IFU_AXI_RLAST = 1'b0;
        LSU_AXI_ARREADY = 1'b0; LSU_AXI_RVALID = 1'b0; LSU_AXI_RID = '0;
        LSU_AXI_RDATA = '0;   LSU_AXI_RRESP = '0; LSU_AXI_RLAST = 1'b0;
        if (gnt_ifu) begin
            AXI_ARVALID = IFU_AXI_ARVALID && !ar_done_q;
            AXI_ARID = IFU_AXI_ARID;       AXI_ARADDR = IFU_AXI_ARADDR;
            AXI_ARLEN = IFU_AXI_ARLEN;     AXI_ARSIZE = IFU_AXI_ARSIZE;
            AXI_ARBURST = IFU_AXI_ARBURST; AXI_ARLOCK = IFU_AXI_ARLOCK;
            AXI_ARCACHE = IFU_AXI_ARCACHE; AXI_ARPROT = IFU_AXI_ARPROT;
            AXI_ARQOS = IFU_AXI_ARQOS;     AXI_ARREGION = IFU_AXI_ARREGION;
            AXI_RREADY = IFU_AXI_RREADY;
            IFU_AXI_ARREADY = AXI_ARREADY && !ar_done_q;
            IFU_AXI_RVALID = AXI_RVALID;   IFU_AXI_RID = AXI_RID;
            IFU_AXI_RDATA = AXI_RDATA;     IFU_AXI_RRESP = AXI_RRESP;
            IFU_AXI_RLAST = AXI_RLAST;
        end else if (gnt_lsu) begin
            AXI_ARVALID = LSU_AXI_ARVALID && !ar_done_q;
            AXI_ARID = LSU_AXI_ARID;       AXI_ARADDR = LSU_AXI_ARADDR;
            AXI_ARLEN = LSU_AXI_ARLEN;     AXI_ARSIZE = LSU_AXI_ARSIZE;
            AXI_ARBURST = LSU_AXI_ARBURST; AXI_ARLOCK = LSU_AXI_ARLOCK;
            AXI_ARCACHE = LSU_AXI_ARCACHE; AXI_ARPROT = LSU_AXI_ARPROT;
            AXI_ARQOS = LSU_AXI_ARQOS;     AXI_ARREGION = LSU_AXI_ARREGION;
            AXI_RREADY = LSU_AXI_RREADY;
            LSU_AXI_ARREADY = AXI_ARREADY && !ar_done_q;
            LSU_AXI_RVALID = AXI_RVALID;   LSU_AXI_RID = AXI_RID;
            LSU_AXI_RDATA = AXI_RDATA;     LSU_AXI_RRESP = AXI_RRESP;
            LSU_AXI_RLAST = AXI_RLAST;
        end
    end

    // Next-state logic: round-robin pick in idle, one address per grant, release on RLAST
    always_comb begin
        state_d    = state_q;
        ar_done_d  = ar_done_q;
        last_lsu_d = last_lsu_q;
        wr_pend_d  = wr_pend_q;
        case (state_q)
            R_IDLE: begin
                if (IFU_AXI_ARVALID && LSU_AXI_ARVALID && !wr_pend_q) begin
                    state_d = last_lsu_q ? R_IFU : R_LSU;
                end else if (IFU_AXI_ARVALID) begin
                    state_d = R_IFU;
                end else if (LSU_AXI_ARVALID && !wr_pend_q) begin
                    state_d = R_LSU;
                end
            end
            R_IFU, R_LSU: begin
                if (AXI_ARVALID && AXI_ARREADY) begin
                    ar_done_d = 1'b1;
                end
                if (AXI_RVALID && AXI_RREADY && AXI_RLAST) begin
                    state_d    = R_IDLE;
                    ar_done_d  = 1'b0;
                    last_lsu_d = (state_q == R_LSU);
                end
            end
            default: state_d = R_IDLE;
        endcase
        if (AXI_AWVALID && AXI_AWREADY) begin
            wr_pend_d = 1'b1;
        end else if (AXI_BVALID && AXI_BREADY) begin
            wr_pend_d = 1'b0;
        end
    end

    // State registers with synchronous reset; IFU wins the first tie after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= R_IDLE;
            ar_done_q  <= 1'b0;
            last_lsu_q <= 1'b1;
            wr_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ar_done_q  <= ar_done_d;
            last_lsu_q <= last_lsu_d;
            wr_pend_q  <= wr_pend_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter: a table of write-path vectors plus
// hand-written read sequences for arbitration, write hold-off and reset.
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [31:0] ifu_araddr;
    logic [63:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_awvalid, ifu_awready, ifu_wvalid, ifu_wready, ifu_bvalid;
    logic [3:0]  unused_ifu_bid;
    logic [1:0]  unused_ifu_bresp;

    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [3:0]  lsu_arid, lsu_rid;
    logic [31:0] lsu_araddr, lsu_awaddr;
    logic [63:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [3:0]  unused_lsu_bid;
    logic [1:0]  unused_lsu_bresp;

    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
    logic [3:0]  axi_arid, axi_rid;
    logic [31:0] axi_araddr, axi_awaddr;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic [7:0]  unused_arlen, unused_awlen;
    logic [2:0]  unused_arsize, unused_arprot, unused_awsize, unused_awprot;
    logic [1:0]  unused_arburst, unused_awburst;
    logic        unused_arlock, unused_awlock, unused_wlast;
    logic [3:0]  unused_arcache, unused_arqos, unused_arregion, unused_awid;
    logic [3:0]  unused_awcache, unused_awqos, unused_awregion;
    logic [63:0] unused_wdata;
    logic [7:0]  unused_wstrb;

    int checks = 0;
    int failures = 0;

    axi_rd_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .IFU_AXI_ARVALID(ifu_arvalid), .IFU_AXI_ARREADY(ifu_arready), .IFU_AXI_ARID(ifu_arid),
        .IFU_AXI_ARADDR(ifu_araddr), .IFU_AXI_ARLEN(8'd0), .IFU_AXI_ARSIZE(3'd3),
        .IFU_AXI_ARBURST(2'd1), .IFU_AXI_ARLOCK(1'b0), .IFU_AXI_ARCACHE(4'd0),
        .IFU_AXI_ARPROT(3'd4), .IFU_AXI_ARQOS(4'd0), .IFU_AXI_ARREGION(4'd0),
        .IFU_AXI_RVALID(ifu_rvalid), .IFU_AXI_RREADY(ifu_rready), .IFU_AXI_RID(ifu_rid),
        .IFU_AXI_RDATA(ifu_rdata), .IFU_AXI_RRESP(ifu_rresp), .IFU_AXI_RLAST(ifu_rlast),
        .IFU_AXI_AWVALID(ifu_awvalid), .IFU_AXI_AWREADY(ifu_awready), .IFU_AXI_AWID(4'd0),
        .IFU_AXI_AWADDR(32'h0), .IFU_AXI_AWLEN(8'd0), .IFU_AXI_AWSIZE(3'd0),
        .IFU_AXI_AWBURST(2'd0), .IFU_AXI_AWLOCK(1'b0), .IFU_AXI_AWCACHE(4'd0),
        .IFU_AXI_AWPROT(3'd0), .IFU_AXI_AWQOS(4'd0), .IFU_AXI_AWREGION(4'd0),
        .IFU_AXI_WVALID(ifu_wvalid), .IFU_AXI_WREADY(ifu_wready), .IFU_AXI_WDATA(64'h0),
        .IFU_AXI_WSTRB(8'h0), .IFU_AXI_WLAST(1'b0), .IFU_AXI_BVALID(ifu_bvalid),
        .IFU_AXI_BREADY(1'b1), .IFU_AXI_BID(unused_ifu_bid), .IFU_AXI_BRESP(unused_ifu_bresp),
        .LSU_AXI_ARVALID(lsu_arvalid), .LSU_AXI_ARREADY(lsu_arready), .LSU_AXI_ARID(lsu_arid),
        .LSU_AXI_ARADDR(lsu_araddr), .LSU_AXI_ARLEN(8'd0), .LSU_AXI_ARSIZE(3'd3),
        .LSU_AXI_ARBURST(2'd1), .LSU_AXI_ARLOCK(1'b0), .LSU_AXI_ARCACHE(4'd0),
        .LSU_AXI_ARPROT(3'd0), .LSU_AXI_ARQOS(4'd0), .LSU_AXI_ARREGION(4'd0),
        .LSU_AXI_RVALID(lsu_rvalid), .LSU_AXI_RREADY(lsu_rready), .LSU_AXI_RID(lsu_rid),
        .LSU_AXI_RDATA(lsu_rdata), .LSU_AXI_RRESP(lsu_rresp), .LSU_AXI_RLAST(lsu_rlast),
        .LSU_AXI_AWVALID(lsu_awvalid), .LSU_AXI_AWREADY(lsu_awready), .LSU_AXI_AWID(4'd2),
        .LSU_AXI_AWADDR(lsu_awaddr), .LSU_AXI_AWLEN(8'd0), .LSU_AXI_AWSIZE(3'd3),
        .LSU_AXI_AWBURST(2'd1), .LSU_AXI_AWLOCK(1'b0), .LSU_AXI_AWCACHE(4'd0),
        .LSU_AXI_AWPROT(3'd0), .LSU_AXI_AWQOS(4'd0), .LSU_AXI_AWREGION(4'd0),
        .LSU_AXI_WVALID(lsu_wvalid), .LSU_AXI_WREADY(lsu_wready), .LSU_AXI_WDATA(64'h55),
        .LSU_AXI_WSTRB(8'hFF), .LSU_AXI_WLAST(1'b1), .LSU_AXI_BVALID(lsu_bvalid),
        .LSU_AXI_BREADY(lsu_bready), .LSU_AXI_BID(unused_lsu_bid), .LSU_AXI_BRESP(unused_lsu_bresp),
        .AXI_ARVALID(axi_arvalid), .AXI_ARREADY(axi_arready), .AXI_ARID(axi_arid),
        .AXI_ARADDR(axi_araddr), .AXI_ARLEN(unused_arlen), .AXI_ARSIZE(unused_arsize),
        .AXI_ARBURST(unused_arburst), .AXI_ARLOCK(unused_arlock), .AXI_ARCACHE(unused_arcache),
        .AXI_ARPROT(unused_arprot), .AXI_ARQOS(unused_arqos), .AXI_ARREGION(unused_arregion),
        .AXI_RVALID(axi_rvalid), .AXI_RREADY(axi_rready), .AXI_RID(axi_rid),
        .AXI_RDATA(axi_rdata), .AXI_RRESP(axi_rresp), .AXI_RLAST(axi_rlast),
        .AXI_AWVALID(axi_awvalid), .AXI_AWREADY(axi_awready), .AXI_AWID(unused_awid),
        .AXI_AWADDR(axi_awaddr), .AXI_AWLEN(unused_awlen), .AXI_AWSIZE(unused_awsize),
        .AXI_AWBURST(unused_awburst), .AXI_AWLOCK(unused_awlock), .AXI_AWCACHE(unused_awcache),
        .AXI_AWPROT(unused_awprot), .AXI_AWQOS(unused_awqos), .AXI_AWREGION(unused_awregion),
        .AXI_WVALID(axi_wvalid), .AXI_WREADY(axi_wready), .AXI_WDATA(unused_wdata),
        .AXI_WSTRB(unused_wstrb), .AXI_WLAST(unused_wlast), .AXI_BVALID(axi_bvalid),
        .AXI_BREADY(axi_bready), .AXI_BID(4'd2), .AXI_BRESP(2'd0)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Write-path vector: stimulus bits and expected
    // {axi_awvalid, axi_wvalid, axi_bready, lsu_awready, lsu_wready, lsu_bvalid, ifu_awready}
    typedef struct {
        logic       lsu_awvalid, lsu_wvalid, lsu_bready;
        logic       axi_awready, axi_wready, axi_bvalid, ifu_awvalid;
        logic [6:0] exp;
    } wr_vec_t;

    wr_vec_t vecs [6];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic ar_hs();
        axi_arready = 1'b1;
        cyc();
        axi_arready = 1'b0;
    endtask

    task automatic r_beat(input logic [63:0] data);
        axi_rvalid = 1'b1;
        axi_rlast  = 1'b1;
        axi_rdata  = data;
        cyc();
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
    endtask

    task automatic apply_stimulus(input wr_vec_t v);
        lsu_awvalid = v.lsu_awvalid; lsu_wvalid = v.lsu_wvalid; lsu_bready = v.lsu_bready;
        axi_awready = v.axi_awready; axi_wready = v.axi_wready; axi_bvalid = v.axi_bvalid;
        ifu_awvalid = v.ifu_awvalid; ifu_wvalid = v.ifu_awvalid;
    endtask

    // Bound the whole run in case something stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs_count;
        ifu_arvalid = 0; ifu_arid = 4'd1; ifu_araddr = 0; ifu_rready = 1;
        ifu_awvalid = 0; ifu_wvalid = 0;
        lsu_arvalid = 0; lsu_arid = 4'd2; lsu_araddr = 0; lsu_rready = 1;
        lsu_awvalid = 0; lsu_awaddr = 0; lsu_wvalid = 0; lsu_bready = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rid = 4'd1; axi_rdata = 0; axi_rresp = 0;
        axi_rlast = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;

        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 7'b0000000};
        vecs[1] = '{1, 0, 0, 0, 0, 0, 0, 7'b1000000};
        vecs[2] = '{0, 0, 0, 1, 1, 0, 0, 7'b0001100};
        vecs[3] = '{0, 1, 1, 0, 0, 1, 0, 7'b0110010};
        vecs[4] = '{0, 0, 0, 1, 0, 0, 1, 7'b0001000};
        vecs[5] = '{1, 1, 1, 1, 1, 1, 1, 7'b1111110};

        // Reset state, sampled while rst is still high and just after release
        rst = 1'b1;
        cyc();
        cyc();
        check_output("rst_state", dut.state_q, 0);
        check_output("rst_last_lsu", dut.last_lsu_q, 1);
        check_output("rst_valids", {axi_arvalid, axi_rready, ifu_arready, lsu_arready,
                                    ifu_rvalid, lsu_rvalid, axi_awvalid, ifu_bvalid}, 0);
        rst = 1'b0;

        // Write-path passthrough table
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("wr_vec%0d", i),
                         {axi_awvalid, axi_wvalid, axi_bready, lsu_awready, lsu_wready,
                          lsu_bvalid, ifu_awready}, vecs[i].exp);
            cyc();
        end
        apply_stimulus(vecs[0]);

        // IFU-only read
        do_reset();
        ifu_arvalid = 1; ifu_arid = 4'd3; ifu_araddr = 32'h8000_0000;
        #1;
        check_output("s1_idle_n", dut.state_q, 0);
        check_output("s1_arvalid_n", axi_arvalid, 0);
        cyc();
        check_output("s1_grant_n1", dut.state_q, 1);
        check_output("s1_arvalid_n1", axi_arvalid, 1);
        check_output("s1_araddr", axi_araddr, 32'h8000_0000);
        check_output("s1_arid", axi_arid, 3);
        axi_arready = 1;
        #1;
        check_output("s1_ifu_arready", {ifu_arready, lsu_arready}, 2'b10);
        cyc();
        ifu_arvalid = 0; axi_arready = 0;
        axi_rvalid = 1; axi_rlast = 1; axi_rid = 4'd3; axi_rresp = 2'd0;
        axi_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        check_output("s1_rdata", ifu_rdata, 64'h1234_5678_9ABC_DEF0);
        check_output("s1_rflags", {ifu_rvalid, ifu_rlast, ifu_rid, axi_rready}, {1'b1, 1'b1, 4'd3, 1'b1});
        check_output("s1_lsu_rvalid", lsu_rvalid, 0);
        check_output("s1_no_reissue", axi_arvalid, 0);
        cyc();
        axi_rvalid = 0; axi_rlast = 0;
        #1;
        check_output("s1_idle_after", dut.state_q, 0);
        check_output("s1_rvalid_after", {ifu_rvalid, lsu_rvalid}, 0);

        // LSU write pending; IFU+LSU tie with last_lsu=0 must still grant IFU
        lsu_awvalid = 1; lsu_awaddr = 32'h8000_0100; lsu_wvalid = 1;
        axi_awready = 1; axi_wready = 1;
        #1;
        check_output("s3_awpass", {axi_awvalid, lsu_awready, axi_wvalid}, 3'b111);
        check_output("s3_awaddr", axi_awaddr, 32'h8000_0100);
        cyc();
        lsu_awvalid = 0; lsu_wvalid = 0; axi_awready = 0; axi_wready = 0;
        lsu_bready = 1;
        lsu_arvalid = 1; lsu_araddr = 32'h0000_0300;
        ifu_arvalid = 1; ifu_araddr = 32'h0000_0400;
        #1;
        check_output("s3_wr_pend", dut.wr_pend_q, 1);
        cyc();
        check_output("s3_ifu_over_pend", dut.state_q, 1);
        check_output("s3_ifu_addr", axi_araddr, 32'h0000_0400);
        ar_hs();
        ifu_arvalid = 0;
        r_beat(64'h1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output($sformatf("s3_hold%0d", i), {axi_arvalid, dut.state_q}, 3'b000);
            cyc();
        end
        axi_bvalid = 1;
        #1;
        check_output("s3_bpass", {lsu_bvalid, axi_bready}, 2'b11);
        check_output("s3_hold_bhs", axi_arvalid, 0);
        cyc();
        axi_bvalid = 0;
        #1;
        check_output("s3_hold_after_b", axi_arvalid, 0);
        cyc();
        check_output("s3_lsu_arvalid", axi_arvalid, 1);
        check_output("s3_lsu_addr", axi_araddr, 32'h0000_0300);
        ar_hs();
        lsu_arvalid = 0;
        axi_rvalid = 1; axi_rlast = 1; axi_rdata = 64'hCAFE;
        #1;
        check_output("s3_lsu_rdata", {lsu_rvalid, ifu_rvalid, lsu_rdata}, {1'b1, 1'b0, 64'hCAFE});
        cyc();
        axi_rvalid = 0; axi_rlast = 0;
        lsu_bready = 0;

        // Same-cycle tie after reset: IFU first, then LSU
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h0000_0100;
        lsu_arvalid = 1; lsu_araddr = 32'h0000_0200;
        cyc();
        check_output("s2_first_ifu", axi_araddr, 32'h0000_0100);
        axi_arready = 1;
        #1;
        check_output("s2_arready", {ifu_arready, lsu_arready}, 2'b10);
        cyc();
        axi_arready = 0; ifu_arvalid = 0;
        r_beat(64'h2);
        check_output("s2_gap", {axi_arvalid, dut.state_q}, 3'b000);
        cyc();
        check_output("s2_second_lsu", dut.state_q, 2);
        check_output("s2_lsu_addr", {axi_arvalid, axi_araddr}, {1'b1, 32'h0000_0200});
        ar_hs();
        lsu_arvalid = 0;
        r_beat(64'h3);
        check_output("s2_idle", dut.state_q, 0);

        // Slave stalls ARREADY for 3 cycles; exactly one AR handshake
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h0000_0500;
        cyc();
        hs_count = 0;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("s4_wait%0d", i), axi_arvalid, 1);
            cyc();
        end
        axi_arready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (axi_arvalid && axi_arready) hs_count++;
            cyc();
        end
        check_output("s4_hs_count", hs_count, 1);
        check_output("s4_no_dup", axi_arvalid, 0);
        axi_arready = 0; ifu_arvalid = 0;
        r_beat(64'h4);

        // Reset in the middle of an LSU burst
        do_reset();
        lsu_arvalid = 1; lsu_araddr = 32'h0000_0700;
        cyc();
        ar_hs();
        lsu_arvalid = 0;
        axi_rvalid = 1; axi_rlast = 0; axi_rdata = 64'hDEAD;
        #1;
        check_output("s5_beat", lsu_rvalid, 1);
        rst = 1;
        #1;
        check_output("s5_rst_quiet", {lsu_rvalid, axi_rready, lsu_arready, axi_arvalid}, 0);
        cyc();
        check_output("s5_state", {dut.state_q, dut.ar_done_q, dut.wr_pend_q, dut.last_lsu_q}, 5'b00001);
        check_output("s5_after_quiet", {lsu_rvalid, axi_rready}, 0);
        rst = 0; axi_rvalid = 0;
        ifu_arvalid = 1; ifu_araddr = 32'h0000_0800;
        cyc();
        check_output("s5_fresh_ar", {axi_arvalid, axi_araddr}, {1'b1, 32'h0000_0800});
        ar_hs();
        ifu_arvalid = 0;
        axi_rvalid = 1; axi_rlast = 1; axi_rdata = 64'hBEEF;
        #1;
        check_output("s5_fresh_r", {ifu_rvalid, ifu_rdata}, {1'b1, 64'hBEEF});
        cyc();
        axi_rvalid = 0; axi_rlast = 0;
        #1;
        check_output("s5_fresh_idle", dut.state_q, 0);

        // IFU write attempts are never answered
        ifu_awvalid = 1; ifu_wvalid = 1; axi_awready = 1; axi_wready = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check_output($sformatf("s6_ifu_wr%0d", i),
                         {ifu_awready, ifu_wready, ifu_bvalid, axi_awvalid}, 0);
            cyc();
        end
        ifu_awvalid = 0; ifu_wvalid = 0; axi_awready = 0; axi_wready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
